dds_hop_sched: RTL
==================

# dds_hop_sched

Frequency-hop scheduler for the DDS datapath. Holds a small programmable table of (FCW, K-index, dwell) entries and, once started, steps through them. It offers each entry's FCW and K-ROM index to the DDS core over a valid/ready update port, holds it for the programmed dwell, then advances. It sits between the host/config logic and the DDS accumulator/K-ROM address registers, replacing their hard-coded constants.

## Interface
- FCW_W, 24, phase-increment width
- KIDX_W, 12, K-ROM address width
- DWELL_W, 16, dwell counter width (cycles)
- DEPTH, 8, table entries (power of two); AW = log2(DEPTH)
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- cfg_we  in  1  table write strobe
- cfg_addr  in  AW  table write address
- cfg_fcw / cfg_kidx / cfg_dwell  in  FCW_W / KIDX_W / DWELL_W  entry data
- cfg_last  in  AW  index of last entry in sequence
- loop_en  in  1  1 = restart at entry 0 after last
- start  in  1  begin sequence (pulse)
- stop  in  1  abort sequence (pulse)
- phase_wrap  in  1  one-cycle pulse on DDS accumulator wrap
- upd_valid  out  1  update offered
- upd_ready  in  1  DDS accepts update
- fcw_out  out  FCW_W  offered/applied FCW
- kidx_out  out  KIDX_W  offered/applied K-ROM index
- hop_idx  out  AW  current table index
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of a non-looping sequence

## Operation
- States: IDLE, OFFER, DWELL, WAIT_WRAP (WAIT_WRAP only with macro).
- Table writes are accepted in any state.
  - The entry being offered or dwelt on is latched into staging at OFFER entry.
  - A write to that entry affects its next visit only.
- IDLE + start: latch cfg_last and loop_en, set idx=0, go to OFFER.
  - start is ignored while busy.
  - start and stop in the same cycle: stop wins, stay IDLE.
- OFFER:
  - upd_valid=1; fcw_out/kidx_out = staged entry.
  - Data is stable while upd_valid && !upd_ready.
  - Transfer (valid && ready): load dwell_cnt = max(dwell,1), go to DWELL.
- DWELL: dwell_cnt decrements each cycle. At dwell_cnt==1, advance:
  - idx != last: idx+1, go to OFFER (or WAIT_WRAP).
  - idx == last && loop_en: idx=0, go to OFFER (or WAIT_WRAP).
  - idx == last && !loop_en: pulse done, go to IDLE.
- stop:
  - In DWELL/WAIT_WRAP: go to IDLE next cycle.
  - In OFFER: set stop_pend and finish the pending handshake (upd_valid is never withdrawn), then go to IDLE.
- fcw_out/kidx_out hold the last transferred value in IDLE/DWELL/WAIT_WRAP.
- Reset:
  - state=IDLE, idx=0, stop_pend=0.
  - All table entries zeroed.
  - Outputs: upd_valid=0, fcw_out=0, kidx_out=0, hop_idx=0, busy=0, done=0.
- Reset mid-sequence abandons any pending offer immediately.

## Timing
- start sampled at cycle T → upd_valid=1 at T+1.
- Transfer at H → DWELL during H+1..H+D.
  - Next upd_valid at H+D+1.
  - With upd_ready tied high, hop period = D+1 cycles.
- done asserts in the cycle after the final DWELL cycle, concurrent with busy falling.
- stop in DWELL at cycle S → busy=0 at S+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- DDS_HOP_WRAP_SYNC_EN defined:
  - After dwell expiry, enter WAIT_WRAP.
  - Move to OFFER in the cycle after a phase_wrap pulse sampled while in WAIT_WRAP.
  - A pulse coincident with dwell expiry does not count.
  - The first hop after start does not wait.
  - Purpose: phase-continuous hops.
- Undefined: WAIT_WRAP is absent, phase_wrap is ignored, and dwell expiry goes straight to OFFER.

## Structure
- Package dds_ctrl_pkg:
  - state enum
  - hop_entry_t struct {fcw, kidx, dwell}
  - default width constants (FCW_W=24, KIDX_W=12, DWELL_W=16, DEPTH=8)
- Sub-module dds_hop_table:
  - DEPTH x hop_entry_t register file
  - synchronous reset-to-zero
  - one write port, combinational read by idx
- FSM, dwell counter and output registers live in dds_hop_sched.

## Test plan
- Reset check: reset high 3 cycles → all outputs 0, busy=0.
- Basic sequence:
  - Setup: entries 0..2 = (6771,2305,4), (13542,100,2), (1000,7,0); cfg_last=2, loop_en=0; upd_ready=1; start.
  - Response: fcw_out 6771 → 13542 → 1000 at 5/3-cycle spacing; dwell 0 acts as 1; done pulses once; busy drops.
- Backpressure: upd_ready low for 6 cycles during an offer → upd_valid and data held stable; dwell starts only after ready.
- loop_en=1, cfg_last=1, run 3 hops → hop_idx sequence 0,1,0; done never asserts.
- Abort and start-ignore:
  - stop during DWELL → busy=0 next cycle.
  - stop during a stalled OFFER → IDLE only after the handshake.
  - start while busy → no effect.
- With DDS_HOP_WRAP_SYNC_EN, phase_wrap every 20 cycles, dwell=4 → each post-dwell upd_valid rises exactly one cycle after a wrap pulse; a coincident pulse is ignored.

Source files
------------

// File: rtl/dds_ctrl_pkg.sv
// dds_ctrl_pkg: shared state type, table entry layout and default widths
// for the DDS frequency-hop scheduler.
package dds_ctrl_pkg;

   localparam int DEF_FCW_W   = 24;
   localparam int DEF_KIDX_W  = 12;
   localparam int DEF_DWELL_W = 16;
   localparam int DEF_DEPTH   = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_OFFER,
      ST_DWELL,
      ST_WAIT_WRAP
   } hop_state_t;

   typedef struct packed {
      logic [DEF_FCW_W-1:0]   fcw;
      logic [DEF_KIDX_W-1:0]  kidx;
      logic [DEF_DWELL_W-1:0] dwell;
   } hop_entry_t;

   localparam int ENTRY_W = $bits(hop_entry_t);

endpackage

// File: rtl/dds_hop_table.sv
// dds_hop_table: DEPTH-entry hop table with one write port, a combinational
// read port and synchronous reset-to-zero.
module dds_hop_table
   import dds_ctrl_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [ENTRY_W-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [ENTRY_W-1:0] rdata
);

   logic [ENTRY_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dds_hop_sched.sv
// dds_hop_sched: steps through a programmable (FCW, K-index, dwell) table and
// offers each hop to the DDS core. Define DDS_HOP_WRAP_SYNC_EN to align hops to phase_wrap.
module dds_hop_sched
   import dds_ctrl_pkg::*;
#(
   parameter int FCW_W   = DEF_FCW_W,
   parameter int KIDX_W  = DEF_KIDX_W,
   parameter int DWELL_W = DEF_DWELL_W,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int AW      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [FCW_W-1:0]  cfg_fcw,
   input  logic [KIDX_W-1:0] cfg_kidx,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [AW-1:0]     cfg_last,
   input  logic              loop_en,
   input  logic              start,
   input  logic              stop,
   input  logic              phase_wrap,
   output logic              upd_valid,
   input  logic              upd_ready,
   output logic [FCW_W-1:0]  fcw_out,
   output logic [KIDX_W-1:0] kidx_out,
   output logic [AW-1:0]     hop_idx,
   output logic              busy,
   output logic              done
);

`ifdef DDS_HOP_WRAP_SYNC_EN
   localparam hop_state_t ST_HOP = ST_WAIT_WRAP;
`else
   localparam hop_state_t ST_HOP = ST_OFFER;
`endif

   hop_state_t         state, state_d;
   logic [AW-1:0]      idx, idx_d, last_q;
   logic               loop_q, stop_pend, stop_pend_d, done_d, load;
   logic [DWELL_W-1:0] dwell_cnt, cnt_d, dwell_st;
   hop_entry_t         wr_ent, rd_ent;
   logic [ENTRY_W-1:0] rd_raw;

   assign wr_ent = '{fcw: cfg_fcw, kidx: cfg_kidx, dwell: cfg_dwell};
   assign rd_ent = hop_entry_t'(rd_raw);

   // Reading at the next index lets staging capture the entry on OFFER entry.
   dds_hop_table #(.DEPTH(DEPTH), .AW(AW)) u_table (
      .clk   (clk),
      .reset (reset),
      .we    (cfg_we),
      .waddr (cfg_addr),
      .wdata (wr_ent),
      .raddr (idx_d),
      .rdata (rd_raw)
   );

   always_comb begin
      state_d     = state;
      idx_d       = idx;
      stop_pend_d = stop_pend;
      cnt_d       = dwell_cnt;
      done_d      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d = ST_OFFER;
               idx_d   = '0;
            end
         end
         ST_OFFER: begin
            stop_pend_d = stop_pend | stop;
            if (upd_ready) begin
               state_d     = stop_pend_d ? ST_IDLE : ST_DWELL;
               stop_pend_d = 1'b0;
               cnt_d       = (dwell_st == '0) ? DWELL_W'(1) : dwell_st;
            end
         end
         ST_DWELL: begin
            cnt_d = dwell_cnt - 1'b1;
            if (stop) begin
               state_d = ST_IDLE;
            end else if (dwell_cnt == DWELL_W'(1)) begin
               done_d  = (idx == last_q) && !loop_q;
               state_d = done_d ? ST_IDLE : ST_HOP;
               idx_d   = (idx == last_q) ? '0 : idx + 1'b1;
            end
         end
         ST_WAIT_WRAP: state_d = stop ? ST_IDLE : phase_wrap ? ST_OFFER : ST_WAIT_WRAP;
         default: state_d = ST_IDLE;
      endcase
      load = (state_d == ST_OFFER) && (state != ST_OFFER);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         idx       <= '0;
         last_q    <= '0;
         loop_q    <= 1'b0;
         stop_pend <= 1'b0;
         dwell_cnt <= '0;
         dwell_st  <= '0;
         fcw_out   <= '0;
         kidx_out  <= '0;
         upd_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_d;
         idx       <= idx_d;
         stop_pend <= stop_pend_d;
         dwell_cnt <= cnt_d;
         upd_valid <= state_d == ST_OFFER;
         busy      <= state_d != ST_IDLE;
         done      <= done_d;
         if (state == ST_IDLE && state_d == ST_OFFER) begin
            last_q <= cfg_last;
            loop_q <= loop_en;
         end
         if (load) begin
            fcw_out  <= rd_ent.fcw;
            kidx_out <= rd_ent.kidx;
            dwell_st <= rd_ent.dwell;
         end
      end
   end

   assign hop_idx = idx;

endmodule
